piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 169 ++++++++++++++++
 tb/tb_piso_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, with a one-word hold register for gap-free streaming.
// Optional even-parity bit after each word when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sout_reg, sout_next;
  logic             sout_valid_reg, sout_valid_next;
  logic             frame_start_reg, frame_start_next;
  logic             hs;
  logic             word_end;
  logic             load;
  logic [WIDTH-1:0] load_word;
`ifdef PISO_PARITY_EN
  logic             par_reg, par_next;
`endif

  assign hs          = data_valid && !hold_full_reg;
  assign data_ready  = !hold_full_reg;
  assign busy        = (state_reg != IDLE) || hold_full_reg;
  assign sout        = sout_reg;
  assign sout_valid  = sout_valid_reg;
  assign frame_start = frame_start_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      hold_reg        <= '0;
      hold_full_reg   <= 1'b0;
      cnt_reg         <= '0;
      sout_reg        <= IDLE_LEVEL;
      sout_valid_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
`ifdef PISO_PARITY_EN
      par_reg         <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      hold_reg        <= hold_next;
      hold_full_reg   <= hold_full_next;
      cnt_reg         <= cnt_next;
      sout_reg        <= sout_next;
      sout_valid_reg  <= sout_valid_next;
      frame_start_reg <= frame_start_next;
`ifdef PISO_PARITY_EN
      par_reg         <= par_next;
`endif
    end
  end

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    hold_next        = hold_reg;
    hold_full_next   = hold_full_reg;
    cnt_next         = cnt_reg;
    frame_start_next = 1'b0;
    word_end         = 1'b0;
    load             = 1'b0;
    load_word        = '0;
`ifdef PISO_PARITY_EN
    par_next         = par_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (hs) begin
          load      = 1'b1;
          load_word = data_in;
        end
      end
      SHIFT: begin
        shift_next = shift_reg << 1;
        cnt_next   = cnt_reg - CW'(1);
        if (hs) begin
          hold_next      = data_in;
          hold_full_next = 1'b1;
        end
        if (cnt_reg == '0) begin
`ifdef PISO_PARITY_EN
          state_next = PARITY;
`else
          word_end   = 1'b1;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (hs) begin
          hold_next      = data_in;
          hold_full_next = 1'b1;
        end
        word_end = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase

    // Hold register wins over a fresh handshake so word order is kept.
    if (word_end) begin
      if (hold_full_reg) begin
        load           = 1'b1;
        load_word      = hold_reg;
        hold_full_next = 1'b0;
      end else if (hs) begin
        load           = 1'b1;
        load_word      = data_in;
        hold_full_next = 1'b0;
      end else begin
        state_next = IDLE;
      end
    end

    if (load) begin
      shift_next       = load_word;
      cnt_next         = CW'(WIDTH - 1);
      state_next       = SHIFT;
      frame_start_next = 1'b1;
`ifdef PISO_PARITY_EN
      par_next         = ^load_word;
`endif
    end

    // Serial outputs are registered copies of what the next state will present.
    case (state_next)
      SHIFT: begin
        sout_next       = shift_next[WIDTH-1];
        sout_valid_next = 1'b1;
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        sout_next       = par_next;
        sout_valid_next = 1'b1;
      end
`endif
      default: begin
        sout_next       = IDLE_LEVEL;
        sout_valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: single word, back-to-back, hold backpressure, reset abort,
// parity framing (PISO_PARITY_EN builds) and a 4-bit instance feeding a 1010 detector model.
module tb_piso_serializer;

  localparam int   W  = 8;
  localparam logic IL = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready, sout, sout_valid, frame_start, busy;
  logic [3:0]   d4_in = '0;
  logic         d4_valid = 1'b0;
  logic         d4_ready, d4_sout, d4_sout_valid, d4_frame_start, d4_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IL)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .sout(sout), .sout_valid(sout_valid),
    .frame_start(frame_start), .busy(busy)
  );

  piso_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(d4_in), .data_valid(d4_valid),
    .data_ready(d4_ready), .sout(d4_sout), .sout_valid(d4_sout_valid),
    .frame_start(d4_frame_start), .busy(d4_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sout"}, 32'(sout), 32'(IL));
    chk({tag, "_valid"}, 32'(sout_valid), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(data_ready), 1);
  endtask

  initial begin
    logic [15:0] pair;
    logic [7:0]  words [3];
    logic [23:0] got;
    logic        rdy;
    logic [3:0]  hist;
    logic [15:0] det;
    int idx, edge_n, acc3, nvalid, nfs, nbit;
    logic [17:0] pstream;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    chk_idle("reset");
    tick();
    tick();
    rst_n = 1'b1;
    chk_idle("post_reset");

`ifndef PISO_PARITY_EN
    // single word A5 from IDLE
    pair = 16'hA5A5;
    data_in = 8'hA5;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("single_bit%0d", k), 32'(sout), 32'(pair[7-k]));
      chk($sformatf("single_valid%0d", k), 32'(sout_valid), 1);
      chk($sformatf("single_fs%0d", k), 32'(frame_start), 32'(k == 0));
      tick();
    end
    chk_idle("single_end");
    $display("txn single A5 checked");

    // A5 then 3C back-to-back
    pair = 16'hA53C;
    data_in = 8'hA5;
    data_valid = 1'b1;
    tick();
    data_in = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("b2b_bit%0d", k), 32'(sout), 32'(pair[15-k]));
      chk($sformatf("b2b_valid%0d", k), 32'(sout_valid), 1);
      chk($sformatf("b2b_fs%0d", k), 32'(frame_start), 32'(k == 0 || k == 8));
      chk($sformatf("b2b_ready%0d", k), 32'(data_ready), 32'(k == 0 || k >= 8));
      tick();
      if (k == 0) data_valid = 1'b0;
    end
    chk_idle("b2b_end");
    $display("txn back-to-back A5,3C checked");

    // three words offered continuously
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    got = '0; idx = 0; edge_n = 0; acc3 = 0; nvalid = 0; nfs = 0;
    for (int c = 0; c < 30; c++) begin
      data_valid = (idx < 3);
      if (idx < 3) data_in = words[idx];
      rdy = data_ready;
      if (sout_valid) begin
        got = {got[22:0], sout};
        nvalid++;
      end
      if (frame_start) nfs++;
      tick();
      edge_n++;
      if (data_valid && rdy) begin
        if (idx == 2) acc3 = edge_n;
        idx++;
      end
    end
    data_valid = 1'b0;
    chk("three_accepted", 32'(idx), 3);
    chk("three_acc3_edge", 32'(acc3), 10);
    chk("three_order", 32'(got), 32'h112233);
    chk("three_nvalid", 32'(nvalid), 24);
    chk("three_nfs", 32'(nfs), 3);
    chk_idle("three_end");
    $display("txn three words 11,22,33 checked");
`else
    // parity: A5 (even parity 0) then 07 (parity 1), 9 cycles each
    pstream = {8'hA5, 1'b0, 8'h07, 1'b1};
    data_in = 8'hA5;
    data_valid = 1'b1;
    tick();
    data_in = 8'h07;
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("par_bit%0d", k), 32'(sout), 32'(pstream[17-k]));
      chk($sformatf("par_valid%0d", k), 32'(sout_valid), 1);
      chk($sformatf("par_fs%0d", k), 32'(frame_start), 32'(k == 0 || k == 9));
      tick();
      if (k == 0) data_valid = 1'b0;
    end
    chk_idle("par_end");
    $display("txn parity A5,07 checked");
`endif

    // reset during bit 4 of FF with 0F in hold
    data_in = 8'hFF;
    data_valid = 1'b1;
    tick();
    data_in = 8'h0F;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_busy", 32'(busy), 1);
    chk("rst_pre_ready", 32'(data_ready), 0);
    chk("rst_pre_bit", 32'(sout), 1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_abort");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("rst_quiet_valid%0d", k), 32'(sout_valid), 0);
      chk($sformatf("rst_quiet_sout%0d", k), 32'(sout), 32'(IL));
      tick();
    end
    chk_idle("rst_quiet_end");
    data_in = 8'h81;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    chk("rst_new_fs", 32'(frame_start), 1);
    chk("rst_new_valid", 32'(sout_valid), 1);
    chk("rst_new_msb", 32'(sout), 1);
    for (int k = 0; k < 12; k++) tick();
    chk_idle("rst_new_end");
    $display("txn reset abort FF/0F then 81 checked");

`ifndef PISO_PARITY_EN
    // WIDTH=4 stream A,A into a 1010 overlapping detector
    hist = '0; det = '0; nbit = 0;
    d4_in = 4'hA;
    d4_valid = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (d4_sout_valid) begin
        nbit++;
        hist = {hist[2:0], d4_sout};
        if (nbit >= 4 && hist == 4'b1010) det[nbit] = 1'b1;
      end
      tick();
      if (k == 0) d4_valid = 1'b0;
    end
    chk("det_bits", 32'(nbit), 8);
    chk("det_pulses", 32'(det), 32'h0150);
    chk("det_idle", 32'(d4_busy), 0);
    $display("txn width4 A,A detector checked");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
